cmsdk_apb3_eg_master_cmd: RTL and testbench
===========================================

CMSDK_APB3_EG_MASTER_CMD -- requirements
Module: cmsdk_apb3_eg_master_cmd

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 12: APB address width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255 (range 1-255): maximum ACCESS wait cycles before abort.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed first:
  PCLK  in  1  clock
  PRESETn  in  1  asynchronous active-low reset
REQ-004 The block SHALL have the following command-side ports:
  req_valid  in  1  command request
  req_ready  out  1  command accepted when high with req_valid
  req_write  in  1  1=write, 0=read
  req_addr  in  ADDRWIDTH  target address
  req_wdata  in  32  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_rdata  out  32  read data (0 for writes and aborts)
  rsp_err  out  1  PSLVERR or timeout
  busy  out  1  high in any state other than IDLE
REQ-005 The block SHALL have the following APB3 master ports:
  PSEL  out  1  slave select
  PADDR  out  ADDRWIDTH  address
  PENABLE  out  1  access phase
  PWRITE  out  1  direction
  PWDATA  out  32  write data
  PRDATA  in  32  read data
  PREADY  in  1  slave ready
  PSLVERR  in  1  slave error

Function
REQ-006 The block SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs SHALL be registered or decoded from the state register only.
REQ-007 In IDLE, req_ready SHALL be 1; in all other states, req_ready SHALL be 0.
REQ-008 On IDLE with req_valid=1, the block SHALL capture req_addr/req_write/req_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
REQ-009 In SETUP, the block SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-010 In ACCESS, the block SHALL drive PSEL=1, PENABLE=1 until PREADY=1 is sampled.
REQ-011 PADDR, PWRITE and PWDATA SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-012 On ACCESS with PREADY=1, the block SHALL set rsp_rdata=PRDATA for reads and 0 for writes, set rsp_err=PSLVERR, and go to RESP.
REQ-013 An 8-bit wait counter SHALL clear on SETUP and increment on each ACCESS cycle with PREADY=0.
REQ-014 When the wait counter equals TIMEOUT with PREADY=0, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-015 If PREADY=1 is sampled in the same cycle the count reaches TIMEOUT, the block SHALL treat the transfer as normal completion (REQ-012 has priority).
REQ-016 PSEL and PENABLE SHALL be 0 in IDLE and RESP; PENABLE SHALL never be 1 while PSEL=0.
REQ-017 In RESP, rsp_valid SHALL be 1; rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1 is sampled, after which the block SHALL go to IDLE.
REQ-018 Latency: a request accepted at edge N SHALL give SETUP in cycle N+1 and ACCESS in N+2; with zero-wait PREADY, rsp_valid SHALL be 1 from N+3. Minimum request-to-request spacing is 4 cycles.
REQ-019 PSLVERR SHALL be ignored except in the ACCESS cycle where PREADY=1.
REQ-020 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-021 On PRESETn=0 (asynchronous, at any time including mid-transfer), the block SHALL immediately set state=IDLE and PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and wait counter=0.
REQ-022 After PRESETn deasserts, req_ready SHALL be 1 from the first clock edge onward.
REQ-023 An interrupted transfer SHALL produce no response.

Verification
REQ-024 The bench SHALL cover a zero-wait write: req addr=0x004, wdata=0xA5A5_0003 -> one SETUP cycle, one ACCESS cycle, then rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-025 The bench SHALL cover a read with 3 wait states returning PRDATA=0x1234_5678 -> PENABLE high for 4 cycles, address stable throughout, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-026 The bench SHALL cover a read completing with PSLVERR=1 -> rsp_err=1, and the FSM SHALL return to IDLE after rsp_ready.
REQ-027 The bench SHALL cover timeout with TIMEOUT=4 and PREADY held 0 -> abort after 4 wait cycles with rsp_err=1, rsp_rdata=0, PSEL=0; and PREADY=1 on the 4th wait cycle -> normal completion.
REQ-028 The bench SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, req_ready=0, and no new APB transfer starts.
REQ-029 The bench SHALL cover PRESETn asserted during ACCESS -> PSEL and PENABLE drop asynchronously, no rsp_valid occurs, and a subsequent request completes normally.

Source files
------------

// File: rtl/cmsdk_apb3_eg_master_cmd_if.sv
// Command-side and APB3-side signal bundle for the APB3 command master.
// The master modport is the controller's view; the slave modport is the view
// of whoever issues commands and models the APB slave.
interface cmsdk_apb3_eg_master_cmd_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 busy;

  logic                 PSEL;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/cmsdk_apb3_eg_master_cmd.sv
// APB3 command master: turns one valid/ready command into one APB3 transfer
// and returns the result on a valid/ready response channel, with an abort
// after TIMEOUT wait cycles.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// SETUP  | APB setup phase, PSEL=1 PENABLE=0, wait counter cleared
// ACCESS | APB access phase, PSEL=1 PENABLE=1 until PREADY or timeout
// RESP   | response presented, held until rsp_ready
module cmsdk_apb3_eg_master_cmd #(
  parameter int ADDRWIDTH = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic PCLK,
  input  logic PRESETn,
  cmsdk_apb3_eg_master_cmd_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t               state, state_nxt;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic                 pwrite_q;
  logic [31:0]          pwdata_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [7:0]           wait_cnt;
  logic [7:0]           wait_inc;
  logic                 timeout_hit;

  // The abort fires on the ACCESS cycle whose wait makes the count reach TIMEOUT.
  assign wait_inc = wait_cnt + 8'd1;

  // Next-state decode; PREADY takes priority over the timeout.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          state_nxt = RESP;
        end else if (wait_inc == TIMEOUT_CNT) begin
          timeout_hit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Command capture, wait counting and response capture.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_wdata;
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          if (bus.PREADY) begin
            rdata_q <= pwrite_q ? 32'd0 : bus.PRDATA;
            err_q   <= bus.PSLVERR;
          end else begin
            wait_cnt <= wait_inc;
            if (timeout_hit) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PSEL      = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_cmsdk_apb3_eg_master_cmd.sv
// Bench for the APB3 command master: directed commands against a small APB
// slave model, expected responses queued at issue time and checked by a
// separate response monitor.
module tb_cmsdk_apb3_eg_master_cmd;
  localparam int AW = 12;
  localparam int TO = 4;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;

  cmsdk_apb3_eg_master_cmd_if #(.ADDRWIDTH(AW)) bus ();

  cmsdk_apb3_eg_master_cmd #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Slave model controls
  int          s_waits = 0;
  logic        s_hang  = 1'b0;
  logic [31:0] s_rdata = 32'd0;
  logic        s_err   = 1'b0;
  logic        s_noise = 1'b0;
  int          acc_cnt = 0;

  always @(posedge PCLK) acc_cnt <= (bus.PSEL && bus.PENABLE) ? acc_cnt + 1 : 0;
  assign bus.PREADY  = bus.PSEL && bus.PENABLE && !s_hang && (acc_cnt == s_waits);
  assign bus.PRDATA  = s_rdata;
  assign bus.PSLVERR = bus.PREADY ? s_err : s_noise;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every presented response must be expected; handshakes are scored.
  always @(negedge PCLK) begin
    if (PRESETn && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response pending");
      end else if (bus.rsp_ready) begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Issue one command and follow it through the APB phases; call at posedge+1 in IDLE.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input logic err,
                         input logic noise, input logic hang, input int bp, input int exp_en,
                         input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t e;
    int   en;
    int   rcyc;
    logic got;
    en   = 0;
    rcyc = 0;
    got  = 1'b0;
    s_waits = waits;
    s_rdata = rdata;
    s_err   = err;
    s_noise = noise;
    s_hang  = hang;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (bp == 0);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge PCLK); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    bus.req_write = ~wr;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin
        got  = 1'b1;
        rcyc = c;
      end else begin
        if (c == 1) chk("setup_penable", 32'(bus.PENABLE), 32'd0);
        if (bus.PENABLE) en++;
        chk("psel_held", 32'(bus.PSEL), 32'd1);
        chk("paddr_stable", 32'(bus.PADDR), 32'(addr));
        chk("pwrite_stable", 32'(bus.PWRITE), 32'(wr));
        chk("pwdata_stable", bus.PWDATA, wdata);
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      chk("access_cycles", 32'(en), 32'(exp_en));
      chk("rsp_cycle", 32'(rcyc), 32'(exp_en + 2));
      chk("resp_psel", 32'(bus.PSEL), 32'd0);
      chk("resp_penable", 32'(bus.PENABLE), 32'd0);
      for (int k = 0; k < bp; k++) begin
        if (k > 0) @(negedge PCLK);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rdata", bus.rsp_rdata, exp_rdata);
        chk("bp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        chk("bp_psel", 32'(bus.PSEL), 32'd0);
        @(posedge PCLK); #1;
        bus.req_valid = 1'b1;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge PCLK); #1;
      chk("back_idle_req_ready", 32'(bus.req_ready), 32'd1);
      chk("back_idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    #12;
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("rst_paddr", 32'(bus.PADDR), 32'd0);
    chk("rst_pwdata", bus.PWDATA, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    //      wr    addr      wdata         waits rdata         err   noise hang  bp en exp_rdata     exp_err
    do_xfer(1'b1, 12'h004, 32'hA5A5_0003, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0, 1, 32'h0000_0000, 1'b0);
    do_xfer(1'b0, 12'h010, 32'h0000_0000, 3, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 0, 4, 32'h1234_5678, 1'b0);
    do_xfer(1'b0, 12'h020, 32'h0000_0000, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0, 2, 32'hDEAD_BEEF, 1'b1);
    do_xfer(1'b0, 12'h030, 32'h0000_0000, 0, 32'h55AA_55AA, 1'b0, 1'b1, 1'b1, 0, 4, 32'h0000_0000, 1'b1);
    do_xfer(1'b1, 12'hFFC, 32'h0F0F_1234, 3, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 0, 4, 32'h0000_0000, 1'b1);
    do_xfer(1'b0, 12'h044, 32'h0000_0000, 0, 32'h0BAD_C0DE, 1'b0, 1'b0, 1'b0, 5, 1, 32'h0BAD_C0DE, 1'b0);
    do_xfer(1'b1, 12'h800, 32'h1111_2222, 0, 32'h3333_4444, 1'b0, 1'b0, 1'b1, 0, 4, 32'h0000_0000, 1'b1);

    // Reset in the middle of an ACCESS phase: no response may follow.
    s_hang        = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 12'h0C0;
    bus.req_wdata = 32'h7777_8888;
    bus.req_valid = 1'b1;
    @(posedge PCLK); #1;
    bus.req_valid = 1'b0;
    @(posedge PCLK); #2;
    chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(bus.PSEL), 32'd0);
    chk("async_rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_paddr", 32'(bus.PADDR), 32'd0);
    chk("async_rst_pwdata", bus.PWDATA, 32'd0);
    chk("async_rst_pwrite", 32'(bus.PWRITE), 32'd0);
    chk("async_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge PCLK);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    s_hang  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge PCLK); #1;
    do_xfer(1'b0, 12'h0C0, 32'h0000_0000, 2, 32'h8765_4321, 1'b0, 1'b0, 1'b0, 0, 3, 32'h8765_4321, 1'b0);

    repeat (3) @(posedge PCLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
